// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: logic/arith/compare ops plus SLL/SRL/SRA, registered result and zero flag.
// Latency: 1 cycle for every op; iterative shifts take 1+shamt cycles unless ALU_FAST_SHIFT_EN is defined.
// Backpressure: result held in DONE until out_ready; in_ready drops while shifting or while a result is stalled.
//
// Ports: clk/rst_n (async active-low), flush (sync abort), in_valid/in_ready/in_op/in_a/in_b (request),
//        out_valid/out_ready/out_result/out_zero (response).
// Build option: define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter (no SHIFT state, accumulator or counter).

package core_types_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;
endpackage

module alu_exec_unit
    import core_types_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_op_t         in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q;
    logic            res_ld;
    logic            in_fire;

`ifndef ALU_FAST_SHIFT_EN
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    alu_op_t         op_q, op_d;
    logic [XLEN-1:0] acc_step;
    logic            start_shift;
`endif

    // Single-cycle result. In the iterative build this only sees shifts with
    // shamt == 0, whose result is simply operand A.
    function automatic logic [XLEN-1:0] alu_compute(alu_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
`ifdef ALU_FAST_SHIFT_EN
        logic [SHW-1:0]  sh;
        sh = b[SHW-1:0];
`endif
        r = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  r = a << sh;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = $unsigned($signed(a) >>> sh);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: r = a;
`endif
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Handshake outputs depend on state and out_ready only.
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
        in_fire   = in_valid && in_ready;
    end

`ifndef ALU_FAST_SHIFT_EN
    always_comb begin
        acc_step = acc_q;
        case (op_q)
            ALU_SLL: acc_step = {acc_q[XLEN-2:0], 1'b0};
            ALU_SRL: acc_step = {1'b0, acc_q[XLEN-1:1]};
            ALU_SRA: acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_step = acc_q;
        endcase
        start_shift = ((in_op == ALU_SLL) || (in_op == ALU_SRL) || (in_op == ALU_SRA))
                      && (in_b[SHW-1:0] != '0);
    end
`endif

    // Next-state and datapath-next logic.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        res_ld   = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
`endif
        if (flush) begin
            // Abort wins over everything, including an accept this cycle.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if ((state_q == DONE) && out_ready) begin
                        state_d = IDLE;
                    end
                    if (in_fire) begin
`ifndef ALU_FAST_SHIFT_EN
                        if (start_shift) begin
                            acc_d   = in_a;
                            cnt_d   = in_b[SHW-1:0];
                            op_d    = in_op;
                            state_d = SHIFT;
                        end else begin
`else
                        begin
`endif
                            result_d = alu_compute(in_op, in_a, in_b);
                            res_ld   = 1'b1;
                            state_d  = DONE;
                        end
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                SHIFT: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        result_d = acc_step;
                        res_ld   = 1'b1;
                        state_d  = DONE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (res_ld) begin
                zero_q <= (result_d == '0);
            end
        end
    end

`ifndef ALU_FAST_SHIFT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= ALU_ADD;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end
`endif

    assign out_result = result_q;
    assign out_zero   = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed scenarios plus randomized traffic.
// Expected results are pushed on accept and popped by an independent output monitor.
// Inputs change 1 time unit after the rising edge; everything is sampled on the falling edge.

module tb_alu_exec_unit;
    import core_types_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
    alu_op_t     in_op;
    logic [31:0] in_a, in_b, out_result;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

`ifdef ALU_FAST_SHIFT_EN
    localparam int SRA4_LAT  = 1;
    localparam int SRA4_BUSY = 0;
`else
    localparam int SRA4_LAT  = 5;
    localparam int SRA4_BUSY = 4;
`endif

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    // Reference model: arithmetic straight from the operation definitions.
    function automatic logic [31:0] model(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        int          s;
        logic [31:0] r;
        logic [31:0] ones;
        s    = int'(b[4:0]);
        ones = 32'hFFFF_FFFF;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_SLL:  r = a << s;
            ALU_SRL:  r = a >> s;
            ALU_SRA: begin
                r = a >> s;
                if (a[31]) r = r | ~(ones >> s);
            end
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    // Scoreboard producer: record the expected response of every accepted op.
    always @(negedge clk) begin
        if (rst_n && !flush && in_valid && in_ready)
            exp_q.push_back(model(in_op, in_a, in_b));
    end

    // Scoreboard consumer: compare every output transfer.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%08h with no op outstanding", out_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", out_result, e);
                    chk1("zero_flag", out_zero, (e == 32'd0));
                end
            end
            if (flush) exp_q.delete();
        end
    end

    // Present an op and hold it until accepted; returns cycles spent waiting.
    task automatic send(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input bit rnd, output int waits);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        waits    = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, required to rise", waits);
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc, output int lat, output int busy);
        lat  = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!in_ready) busy++;
        end while (!out_valid && lat < maxc);
    endtask

    task automatic one(input string name, input alu_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat);
        int w, lat, busy;
        send(op, a, b, 1'b0, w);
        in_valid = 1'b0;
        wait_valid(100, lat, busy);
        chk(name, lat, exp_lat);
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_result"}, out_result, 32'd0);
        chk1({tag, "_out_zero"}, out_zero, 1'b0);
    endtask

    initial begin
        int          w0, w1, w2, lat, busy, nvalid;
        logic [31:0] exp_and, ra, rb;
        alu_op_t     rop;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = ALU_ADD; in_a = '0; in_b = '0;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic arithmetic and compares.
        one("lat_add", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1);
        one("lat_sub", ALU_SUB, 32'd5, 32'd5, 1);
        one("lat_slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1);
        one("lat_sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1);

        // SRA by 4 with upper shamt bits set.
        send(ALU_SRA, 32'h8000_0000, 32'h24, 1'b0, w0);
        in_valid = 1'b0;
        wait_valid(100, lat, busy);
        chk("lat_sra4", lat, SRA4_LAT);
        chk("busy_sra4", busy, SRA4_BUSY);

        // Back-to-back logic ops with in_valid held.
        @(posedge clk); #1;
        send(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, w0);
        send(ALU_OR,  32'h1200_0034, 32'h0000_5600, 1'b0, w1);
        send(ALU_AND, 32'hDEAD_BEEF, 32'hFF00_FF0F, 1'b0, w2);
        chk("b2b_wait0", w0, 0);
        chk("b2b_wait1", w1, 0);
        chk("b2b_wait2", w2, 0);
        exp_and = 32'hDE00_BE0F;

        // Stall the AND result for 3 cycles with a new op waiting.
        out_ready = 1'b0;
        in_op = ALU_ADD; in_a = 32'h11; in_b = 32'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stall_out_valid", out_valid, 1'b1);
            chk1("stall_in_ready", in_ready, 1'b0);
            chk("stall_result", out_result, exp_and);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(ALU_ADD, 32'h11, 32'h22, 1'b0, w0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Long shift aborted by flush on its 10th shifting cycle.
        send(ALU_SLL, 32'd1, 32'd31, 1'b0, w0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) nvalid++;
        end
        chk("flush_no_valid", nvalid, 0);
        @(posedge clk); #1;
        one("lat_add_after_flush", ALU_ADD, 32'd2, 32'd3, 1);

        // Reset during a shift.
        @(posedge clk); #1;
        send(ALU_SLL, 32'd3, 32'd20, 1'b0, w0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_values("rst_shift");
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset while a result is stalled in DONE.
        out_ready = 1'b0;
        send(ALU_ADD, 32'd1, 32'd1, 1'b0, w0);
        in_valid = 1'b0;
        @(negedge clk);
        chk1("done_before_rst", out_valid, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check_reset_values("rst_done");
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;

        // Zero shift amount passes A through; undefined op yields 0.
        one("lat_srl0", ALU_SRL, 32'hDEAD_BEEF, 32'h20, 1);
        one("lat_sra0", ALU_SRA, 32'h8000_0001, 32'h40, 1);
        one("lat_undef", alu_op_t'(4'd12), 32'd5, 32'd6, 1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            rop = alu_op_t'(4'($urandom_range(0, 11)));
            case ($urandom_range(0, 4))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            out_ready = ($urandom_range(0, 3) != 0);
            send(rop, ra, rb, 1'b1, w0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
